// File: rtl/anode_scan_controller_pkg.sv
// rtl/anode_scan_controller_pkg.sv - shared constants and ring state type for the anode scan controller
//
// Purpose : anode strobe codes, blanking code, digit count and the ring state
//           enum used by anode_scan_controller.
// Ports   : none (package).
package scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low anode patterns as {AN3,AN2,AN1,AN0}.
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  // Non-BCD code that the downstream decoder renders as all segments off.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // The ring state encoding is the anode pattern itself, so the state
  // register drives the anode pins directly with no decode.
  typedef enum logic [3:0] {
    S_DIG0 = AN_DIG0,
    S_DIG1 = AN_DIG1,
    S_DIG2 = AN_DIG2,
    S_DIG3 = AN_DIG3
  } ring_state_e;

endpackage

// File: rtl/anode_scan_controller_if.sv
// rtl/anode_scan_controller_if.sv - display data and anode strobe bundle for the anode scan controller
//
// Purpose : groups the datapath-facing inputs and decoder/pin-facing outputs.
// Signals : BCD_in[15:0], load, blank_lz   (datapath -> controller)
//           AN3..AN0, BCD_out[15:0], frame_done (controller -> decoder/pins)
// Modports: master = datapath/top-level side, slave = anode_scan_controller.
interface anode_scan_controller_if;

  logic [15:0] BCD_in;
  logic        load;
  logic        blank_lz;
  logic        AN3;
  logic        AN2;
  logic        AN1;
  logic        AN0;
  logic [15:0] BCD_out;
  logic        frame_done;

  modport master (
    output BCD_in, load, blank_lz,
    input  AN3, AN2, AN1, AN0, BCD_out, frame_done
  );

  modport slave (
    input  BCD_in, load, blank_lz,
    output AN3, AN2, AN1, AN0, BCD_out, frame_done
  );

endinterface

// File: rtl/anode_scan_controller_refresh_prescaler.sv
// rtl/anode_scan_controller_refresh_prescaler.sv - digit dwell prescaler producing a one-cycle tick
//
// Purpose : counts 0..REFRESH_DIV-1 and wraps; tick is high in the last count.
// Ports   : clk   - system clock
//           reset - synchronous active-high reset (count returns to 0)
//           tick  - high while the count equals REFRESH_DIV-1
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = w_last;

endmodule

// File: rtl/anode_scan_controller.sv
// rtl/anode_scan_controller.sv - 4-digit seven-segment anode multiplexer with frame-synchronous BCD update
//
// Purpose : rotates a one-hot-low anode ring every REFRESH_DIV cycles, holds the
//           displayed BCD word in a double buffer committed at frame wrap, and
//           applies optional leading-zero blanking.
// Ports   : clk   - system clock
//           reset - synchronous active-high reset
//           bus   - anode_scan_controller_if.slave (BCD_in, load, blank_lz in;
//                   AN3..AN0, BCD_out, frame_done out)
module anode_scan_controller
  import scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  anode_scan_controller_if.slave bus
);

  logic        w_tick;
  logic        w_boundary;
  ring_state_e r_ring;
  ring_state_e w_ring_next;

  logic [15:0] r_disp;
  logic [15:0] r_pend;
  logic        r_pend_v;
  logic        r_blank_q;
  logic        r_frame_done;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Ring state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ring <= S_DIG0;
    end else begin
      r_ring <= w_ring_next;
    end
  end

  // Ring next state; the wrap out of the last digit is the frame boundary.
  always_comb begin
    w_ring_next = r_ring;
    w_boundary  = 1'b0;
    if (w_tick) begin
      case (r_ring)
        S_DIG0:  w_ring_next = S_DIG1;
        S_DIG1:  w_ring_next = S_DIG2;
        S_DIG2:  w_ring_next = S_DIG3;
        S_DIG3: begin
          w_ring_next = S_DIG0;
          w_boundary  = 1'b1;
        end
        default: w_ring_next = S_DIG0;
      endcase
    end
  end

  // Double buffer. A load coinciding with the boundary goes straight to the
  // display so the freshest value wins over an older pending one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp       <= 16'h0000;
      r_pend       <= 16'h0000;
      r_pend_v     <= 1'b0;
      r_blank_q    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (bus.load) begin
        r_pend <= bus.BCD_in;
      end
      if (w_boundary) begin
        if (bus.load) begin
          r_disp <= bus.BCD_in;
        end else if (r_pend_v) begin
          r_disp <= r_pend;
        end
        r_pend_v  <= 1'b0;
        r_blank_q <= bus.blank_lz;
      end else if (bus.load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  // Replace leading zero digits (never digit 0) with the blank code.
  function automatic logic [15:0] apply_blanking(input logic [15:0] word, input logic en);
    logic [15:0] res;
    logic        lead;
    res  = word;
    lead = en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lead = lead && (word[4*k +: 4] == 4'h0);
      if (lead) begin
        res[4*k +: 4] = BLANK_CODE;
      end
    end
    return res;
  endfunction

  assign {bus.AN3, bus.AN2, bus.AN1, bus.AN0} = r_ring;
  assign bus.BCD_out    = apply_blanking(r_disp, r_blank_q);
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_anode_scan_controller.sv
// tb/tb_anode_scan_controller.sv - self-checking bench for anode_scan_controller
module tb_anode_scan_controller;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk;
  logic reset;
  int   checks_total;
  int   checks_passed;

  // Reference model state: t is the index of the cycle currently shown
  // since the last reset release.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pend_v;
  logic        m_blank;
  logic        m_fd;

  anode_scan_controller_if bus ();

  anode_scan_controller #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_anodes(input int tt);
    logic [3:0] a;
    a = 4'b1111;
    a[(tt / DIV) % 4] = 1'b0;
    return {12'h000, a};
  endfunction

  // Count leading zero digits among digits 3..1, then replace that many.
  function automatic logic [15:0] exp_bcd(input logic [15:0] w, input logic blank);
    logic [15:0] r;
    int          nz;
    r  = w;
    nz = 0;
    if (blank) begin
      while (nz < 3 && ((w >> (4 * (3 - nz))) & 16'hF) == 16'h0) nz++;
    end
    for (int i = 0; i < nz; i++) r = r | (16'hF << (4 * (3 - i)));
    return r;
  endfunction

  function automatic logic [15:0] anodes_now();
    return {12'h000, bus.AN3, bus.AN2, bus.AN1, bus.AN0};
  endfunction

  task automatic step();
    logic bnd;
    @(posedge clk);
    if (reset) begin
      t        = 0;
      m_disp   = 16'h0000;
      m_pend   = 16'h0000;
      m_pend_v = 1'b0;
      m_blank  = 1'b0;
      m_fd     = 1'b0;
    end else begin
      bnd = ((t % FRAME) == FRAME - 1);
      if (bnd) begin
        if (bus.load) m_disp = bus.BCD_in;
        else if (m_pend_v) m_disp = m_pend;
        m_pend_v = 1'b0;
        m_blank  = bus.blank_lz;
      end else if (bus.load) begin
        m_pend   = bus.BCD_in;
        m_pend_v = 1'b1;
      end
      m_fd = bnd;
      t++;
    end
    #1;
    check("anodes", anodes_now(), exp_anodes(t));
    check("bcd_out", bus.BCD_out, exp_bcd(m_disp, m_blank));
    check("frame_done", {15'h0, bus.frame_done}, {15'h0, m_fd});
  endtask

  task automatic run_until(input int ph);
    while ((t % FRAME) != ph) step();
  endtask

  // Load on the boundary cycle so the value lands in the display at once.
  task automatic load_at_boundary(input logic [15:0] v);
    run_until(FRAME - 1);
    bus.load   = 1'b1;
    bus.BCD_in = v;
    step();
    bus.load   = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    int fd_count;
    checks_total  = 0;
    checks_passed = 0;
    t             = 0;
    reset         = 1'b1;
    bus.load      = 1'b1;
    bus.BCD_in    = 16'hABCD;
    bus.blank_lz  = 1'b0;

    // Reset with a load held high: the load must be ignored.
    step();
    step();
    check("reset_anodes", anodes_now(), 16'h000E);
    check("reset_bcd", bus.BCD_out, 16'h0000);
    reset    = 1'b0;
    bus.load = 1'b0;

    // Scan and frame_done cadence.
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_done) fd_count++;
    end
    check("fd_per_two_frames", 16'(fd_count), 16'd2);

    // Deferred update: load during digit 1, visible only at the wrap.
    run_until(DIV);
    bus.load   = 1'b1;
    bus.BCD_in = 16'h1234;
    step();
    bus.load   = 1'b0;
    run_until(FRAME - 1);
    check("deferred_pre", bus.BCD_out, 16'h0000);
    step();
    check("deferred_post", bus.BCD_out, 16'h1234);
    check("deferred_an0", anodes_now(), 16'h000E);

    // Simultaneous load and boundary beats an older pending value.
    run_until(2);
    bus.load   = 1'b1;
    bus.BCD_in = 16'h9999;
    step();
    bus.load   = 1'b0;
    load_at_boundary(16'h0042);
    check("simul_load", bus.BCD_out, 16'h0042);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load_at_boundary(16'h0042);
    check("blank_0042", bus.BCD_out, 16'hFF42);
    load_at_boundary(16'h0000);
    check("blank_0000", bus.BCD_out, 16'hFFF0);
    load_at_boundary(16'h1002);
    check("blank_1002", bus.BCD_out, 16'h1002);
    bus.blank_lz = 1'b0;
    load_at_boundary(16'h0042);
    check("noblank_0042", bus.BCD_out, 16'h0042);

    // Reset mid-frame with a pending value.
    run_until(5);
    bus.load   = 1'b1;
    bus.BCD_in = 16'h5555;
    step();
    bus.load   = 1'b0;
    run_until(2 * DIV + 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_anodes", anodes_now(), 16'h000E);
    check("midreset_bcd", bus.BCD_out, 16'h0000);
    for (int i = 0; i < FRAME + 2; i++) step();
    check("midreset_no_pend", bus.BCD_out, 16'h0000);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.BCD_in   = rand_bcd();
      bus.blank_lz = 1'($urandom_range(0, 1));
      step();
    end
    reset    = 1'b0;
    bus.load = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/anode_scan_controller.md
# anode_scan_controller

Time-multiplexing driver for the 4-digit seven-segment display. It generates the active-low anode strobes `AN3..AN0` that select each digit in turn, and presents the 16-bit BCD word to the downstream BCD-to-segment decoder. The BCD word is double-buffered so updates take effect only at frame boundaries, and optional leading-zero blanking forces unused upper digits to the non-BCD code `4'hF`, which the decoder renders as all segments off. It sits between the counter/arithmetic datapath and the segment decoder in every display top level.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal range ≥ 2. At 100 MHz this gives 2 kHz per digit and a 500 Hz frame.
- `clk` input, 1 bit: system clock. The block uses one clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `BCD_in` input, 16 bits: new value; digit 3 is `[15:12]`, digit 0 is `[3:0]`.
- `load` input, 1 bit: single-cycle strobe that captures `BCD_in` into the pending buffer.
- `blank_lz` input, 1 bit: leading-zero blanking enable, sampled at commit.
- `AN3`, `AN2`, `AN1`, `AN0` outputs, 1 bit each: anode enables, active-low, exactly one low at all times.
- `BCD_out` output, 16 bits: displayed word after blanking; feeds the segment decoder.
- `frame_done` output, 1 bit: one-cycle pulse on each frame wrap.

## Operation
- **Prescaler.** `cnt` counts 0 to `REFRESH_DIV-1` and then wraps to 0. `tick` is asserted when `cnt == REFRESH_DIV-1`. Counter width is `$clog2(REFRESH_DIV)`.
- **Anode ring.** `{AN3,AN2,AN1,AN0}` is a rotating one-hot-low register: 1110 → 1101 → 1011 → 0111 → 1110. It rotates on `tick` only.
- **Frame boundary.** A frame boundary is `tick` while the ring is 0111. On that edge:
  - the ring returns to 1110;
  - the commit happens;
  - `frame_done` is registered high for the following cycle.
- **Pending buffer.** `load` writes `BCD_in` into `pend` and sets `pend_v`. A later `load` before the boundary overwrites `pend`; only the last value is kept.
- **Commit.** At the boundary, if `load` is high in the same cycle, `disp <= BCD_in`. Otherwise, if `pend_v` is set, `disp <= pend`. In both cases `pend_v` clears and `blank_q <= blank_lz`. If neither `load` nor `pend_v`, `disp` holds, but `blank_q` still samples `blank_lz`.
- **Blanking.** Computed combinationally from `disp` and `blank_q`.
  - Digit k (k = 3, 2, 1) outputs `4'hF` when `blank_q` is high and digit k and every higher digit of `disp` are 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- **Non-BCD nibbles.** Nibbles above 9 pass through unchanged; the decoder blanks them.

## Timing
- **Reset values:**
  - `cnt` = 0, ring = 1110 (`AN0` low, others high)
  - `disp` = 16'h0000, `pend` = 16'h0000, `pend_v` = 0, `blank_q` = 0
  - `frame_done` = 0, `BCD_out` = 16'h0000
- **Dwell.** Each anode is low for exactly `REFRESH_DIV` cycles, including the first digit after reset. A frame is `4*REFRESH_DIV` cycles.
- **Update latency.** A `load` becomes visible on `BCD_out` at the next frame boundary edge, which is between 1 and `4*REFRESH_DIV` cycles later. It is never visible mid-frame.
- **`frame_done`** is high for exactly one cycle: the first cycle in which `AN0` is low in the new frame.
- **Reset mid-frame.** Reset discards the pending value and restarts at digit 0 with `cnt` = 0 on the cycle after `reset` falls.
- **`load` during reset** is ignored.

## Structure
- **Package `scan_pkg`:**
  - `AN_DIG0..AN_DIG3` constants (4'b1110, 4'b1101, 4'b1011, 4'b0111)
  - `BLANK_CODE` = 4'hF
  - `NUM_DIGITS` = 4
- **Sub-module `refresh_prescaler`:** parameterised by `REFRESH_DIV`; ports `clk`, `reset`, `tick`. It is reused by other multiplexed display blocks.
- **Blanking** is a combinational function inside the block, not a separate module.

## Test plan
All scenarios use `REFRESH_DIV` = 4.
1. **Reset and scan.** Release reset → anodes follow 1110, 1101, 1011, 0111, 1110 with exactly 4 cycles per state. `frame_done` pulses once per 16 cycles, on the cycle after the 0111 → 1110 edge.
2. **Deferred update.** Pulse `load` with 16'h1234 while the ring is 1101 → `BCD_out` stays 16'h0000 until the frame-boundary edge, then becomes 16'h1234 together with `AN0` going low.
3. **Simultaneous load and boundary.** `load` with 16'h0042 on the boundary cycle, while `pend` holds 16'h9999 → `BCD_out` = 16'h0042.
4. **Blanking.** `blank_lz` = 1, load 16'h0042 → `BCD_out` = 16'hFF42. Load 16'h0000 → 16'hFFF0. Load 16'h1002 → 16'h1002. Repeat with `blank_lz` = 0 → 16'h0042.
5. **Reset mid-frame.** Assert `reset` for 1 cycle while the ring is 1011 and a load is pending → anodes = 1110, `cnt` = 0, `BCD_out` = 16'h0000. The pending value is never displayed.
